// File: rtl/biu_mp.sv
// biu_mp: round-robin bridge from NUM_REQ line/beat requesters onto one AXI-lite master.
// Optional watchdog on every handshake wait is compiled in with `define BIU_MP_TIMEOUT_EN.
module biu_mp #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 64,
    parameter int BEAT_W      = 64,
    parameter int LINE_W      = 512,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_vld_i,
    output logic [NUM_REQ-1:0]           req_rdy_o,
    input  logic [NUM_REQ-1:0]           req_rd_i,
    input  logic [NUM_REQ-1:0]           req_line_i,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr_i,
    input  logic [NUM_REQ*LINE_W-1:0]    req_wdata_i,
    input  logic [NUM_REQ*BEAT_W/8-1:0]  req_wstrb_i,
    output logic [NUM_REQ-1:0]           resp_vld_o,
    input  logic [NUM_REQ-1:0]           resp_rdy_i,
    output logic [LINE_W-1:0]            resp_rdata_o,
    output logic                         resp_err_o,
    output logic                         awvalid_o,
    input  logic                         awready_i,
    output logic [ADDR_W-1:0]            awaddr_o,
    output logic [2:0]                   awprot_o,
    output logic                         wvalid_o,
    input  logic                         wready_i,
    output logic [BEAT_W-1:0]            wdata_o,
    output logic [BEAT_W/8-1:0]          wstrb_o,
    input  logic                         bvalid_i,
    output logic                         bready_o,
    input  logic [1:0]                   bresp_i,
    output logic                         arvalid_o,
    input  logic                         arready_i,
    output logic [ADDR_W-1:0]            araddr_o,
    output logic [2:0]                   arprot_o,
    input  logic                         rvalid_i,
    output logic                         rready_o,
    input  logic [BEAT_W-1:0]            rdata_i,
    input  logic [1:0]                   rresp_i
);

    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int STRB_W = BEAT_W / 8;
    localparam int BCW    = $clog2(BEATS);
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LOFF   = $clog2(LINE_W / 8);
    localparam int BOFF   = $clog2(BEAT_W / 8);

    if (NUM_REQ < 1 || NUM_REQ > 8 || BEATS < 2 || BEATS > 16 || BEAT_W < 32 || TIMEOUT_CYC < 1)
    begin : g_param_check
        $error("biu_mp: unsupported parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RESP} state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    rr_ptr_q, port_q;
    logic                line_q, err_q, aw_done_q, w_done_q;
    logic [ADDR_W-1:0]   addr_q, araddr_q, awaddr_q;
    logic [LINE_W-1:0]   wdata_q, rdata_q;
    logic [BCW-1:0]      beat_q;
    logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic [BEAT_W-1:0]   wbeat_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [NUM_REQ-1:0]  resp_vld_q;

    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    gidx;
    logic                found;
    int                  idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LINE_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_wstrb;
    logic                sel_line, sel_rd, accept, last_beat, aw_done_nx, w_done_nx;
    logic [BCW-1:0]      beat_nx;
    logic                unused_resp;

    // Search for the first valid port starting at rr_ptr, wrapping around.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && req_vld_i[idx]) begin
                found     = 1'b1;
                grant[idx] = 1'b1;
                gidx      = PTR_W'(idx);
            end
        end
    end

    assign req_rdy_o  = (state_q == S_IDLE) ? grant : '0;
    assign accept     = |(req_vld_i & req_rdy_o);
    assign sel_addr   = req_addr_i[int'(gidx)*ADDR_W +: ADDR_W];
    assign sel_wdata  = req_wdata_i[int'(gidx)*LINE_W +: LINE_W];
    assign sel_wstrb  = req_wstrb_i[int'(gidx)*STRB_W +: STRB_W];
    assign sel_line   = req_line_i[gidx];
    assign sel_rd     = req_rd_i[gidx];
    assign last_beat  = line_q ? (beat_q == BCW'(BEATS - 1)) : 1'b1;
    assign beat_nx    = BCW'(beat_q + 1'b1);
    assign aw_done_nx = aw_done_q | (awvalid_q & awready_i);
    assign w_done_nx  = w_done_q | (wvalid_q & wready_i);
    assign unused_resp = rresp_i[0] ^ bresp_i[0];

    // Line beats stay inside the line (low address bits ignored); single beats are beat-aligned.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                    input logic ln, input logic [BCW-1:0] b);
        logic [ADDR_W-1:0] r;
        if (ln) r = ((a >> LOFF) << LOFF) + (ADDR_W'(b) << BOFF);
        else    r = (a >> BOFF) << BOFF;
        return r;
    endfunction

`ifdef BIU_MP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             waiting, progress;
    always_comb begin
        waiting  = (state_q == S_AR) || (state_q == S_R) || (state_q == S_AW_W) || (state_q == S_B);
        progress = ((state_q == S_AR) && arready_i) || ((state_q == S_R) && rvalid_i) ||
                   ((state_q == S_AW_W) && aw_done_nx && w_done_nx) || ((state_q == S_B) && bvalid_i);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            port_q     <= '0;
            line_q     <= 1'b0;
            err_q      <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            addr_q     <= '0;
            araddr_q   <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            beat_q     <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            wbeat_q    <= '0;
            wstrb_q    <= '0;
            resp_vld_q <= '0;
`ifdef BIU_MP_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    port_q   <= gidx;
                    line_q   <= sel_line;
                    addr_q   <= sel_addr;
                    wdata_q  <= sel_wdata;
                    beat_q   <= '0;
                    err_q    <= 1'b0;
                    rdata_q  <= '0;
                    rr_ptr_q <= (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(gidx + 1'b1);
                    if (sel_rd) begin
                        state_q   <= S_AR;
                        arvalid_q <= 1'b1;
                        araddr_q  <= beat_addr(sel_addr, sel_line, '0);
                    end else begin
                        state_q   <= S_AW_W;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        awaddr_q  <= beat_addr(sel_addr, sel_line, '0);
                        wbeat_q   <= sel_wdata[BEAT_W-1:0];
                        wstrb_q   <= sel_line ? '1 : sel_wstrb;
                    end
                end
                S_AR: if (arready_i) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= S_R;
                end
                S_R: if (rvalid_i) begin
                    rdata_q[int'(beat_q)*BEAT_W +: BEAT_W] <= rdata_i;
                    err_q    <= err_q | rresp_i[1];
                    rready_q <= 1'b0;
                    if (last_beat) begin
                        state_q    <= S_RESP;
                        resp_vld_q <= NUM_REQ'(1) << port_q;
                    end else begin
                        beat_q    <= beat_nx;
                        arvalid_q <= 1'b1;
                        araddr_q  <= beat_addr(addr_q, line_q, beat_nx);
                        state_q   <= S_AR;
                    end
                end
                // AW and W complete independently; B waits until both have been accepted.
                S_AW_W: begin
                    awvalid_q <= ~aw_done_nx;
                    wvalid_q  <= ~w_done_nx;
                    aw_done_q <= aw_done_nx;
                    w_done_q  <= w_done_nx;
                    if (aw_done_nx && w_done_nx) begin
                        bready_q <= 1'b1;
                        state_q  <= S_B;
                    end
                end
                S_B: if (bvalid_i) begin
                    err_q    <= err_q | bresp_i[1];
                    bready_q <= 1'b0;
                    if (last_beat) begin
                        state_q    <= S_RESP;
                        resp_vld_q <= NUM_REQ'(1) << port_q;
                    end else begin
                        beat_q    <= beat_nx;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        awaddr_q  <= beat_addr(addr_q, line_q, beat_nx);
                        wbeat_q   <= wdata_q[int'(beat_nx)*BEAT_W +: BEAT_W];
                        state_q   <= S_AW_W;
                    end
                end
                S_RESP: if (resp_rdy_i[port_q]) begin
                    resp_vld_q <= '0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
`ifdef BIU_MP_TIMEOUT_EN
            // Overrides the case above when a wait has run out; unfinished beats stay zero.
            if (waiting && !progress) begin
                if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    arvalid_q  <= 1'b0;
                    rready_q   <= 1'b0;
                    awvalid_q  <= 1'b0;
                    wvalid_q   <= 1'b0;
                    bready_q   <= 1'b0;
                    err_q      <= 1'b1;
                    resp_vld_q <= NUM_REQ'(1) << port_q;
                    state_q    <= S_RESP;
                    tmo_q      <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
`endif
        end
    end

    assign resp_vld_o   = resp_vld_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign awvalid_o    = awvalid_q;
    assign awaddr_o     = awaddr_q;
    assign awprot_o     = 3'b000;
    assign wvalid_o     = wvalid_q;
    assign wdata_o      = wbeat_q;
    assign wstrb_o      = wstrb_q;
    assign bready_o     = bready_q;
    assign arvalid_o    = arvalid_q;
    assign araddr_o     = araddr_q;
    assign arprot_o     = 3'b000;
    assign rready_o     = rready_q;

endmodule

// File: tb/tb_biu_mp.sv
// Directed bench for biu_mp (default build): a negedge-driven AXI-lite slave model plus
// a linear sequence of transactions checked with immediate assertions.
module tb_biu_mp;
    localparam int NR = 2, AW = 64, BW = 64, LW = 512, SW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_vld_i = '0, req_rdy_o, req_rd_i = '0, req_line_i = '0;
    logic [NR*AW-1:0] req_addr_i = '0;
    logic [NR*LW-1:0] req_wdata_i = '0;
    logic [NR*SW-1:0] req_wstrb_i = '0;
    logic [NR-1:0]    resp_vld_o, resp_rdy_i = '1;
    logic [LW-1:0]    resp_rdata_o;
    logic             resp_err_o;
    logic             awvalid_o, awready_i = 1'b0, wvalid_o, wready_i = 1'b0;
    logic             bvalid_i = 1'b0, bready_o, arvalid_o, arready_i = 1'b0;
    logic             rvalid_i = 1'b0, rready_o;
    logic [AW-1:0]    awaddr_o, araddr_o;
    logic [2:0]       awprot_o, arprot_o;
    logic [BW-1:0]    wdata_o, rdata_i = '0;
    logic [SW-1:0]    wstrb_o;
    logic [1:0]       bresp_i = '0, rresp_i = '0;

    biu_mp dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_rd_i(req_rd_i), .req_line_i(req_line_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .resp_vld_o(resp_vld_o), .resp_rdy_i(resp_rdy_i), .resp_rdata_o(resp_rdata_o),
        .resp_err_o(resp_err_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awprot_o(awprot_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arprot_o(arprot_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i)
    );

    // Slave knobs, written only by the main sequence
    int          aw_wait = 0;
    bit          ar_never = 1'b0;
    bit          rd_fixed = 1'b0;
    logic [63:0] rd_fixed_val = '0;
    logic [63:0] err_araddr = '1;

    // Slave logs and protocol-violation counter, written only by the slave process
    logic [63:0] ar_log[$];
    logic [63:0] aw_log[$];
    logic [63:0] w_log[$];
    logic [7:0]  ws_log[$];
    int          b_cnt = 0;
    int          prot_err = 0;
    int          aw_cnt = 0;
    logic [63:0] r_addr = '0, ar_prev = '0, aw_prev = '0;
    bit          ar_pend = 1'b0, aw_pend = 1'b0;

    int tests = 0;
    int fails = 0;

    function automatic logic [63:0] rpat(input logic [63:0] a);
        return {32'hA000_0000 + a[31:0], ~a[31:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            arready_i = 1'b0; rvalid_i = 1'b0; awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
            rresp_i = 2'b00; bresp_i = 2'b00; aw_cnt = 0; ar_pend = 1'b0; aw_pend = 1'b0;
        end else begin
            if (ar_pend && (!arvalid_o || araddr_o != ar_prev)) prot_err++;
            if (aw_pend && (!awvalid_o || awaddr_o != aw_prev)) prot_err++;
            if (bready_o && (awvalid_o || wvalid_o)) prot_err++;
            arready_i = arvalid_o && !ar_never;
            if (arvalid_o && arready_i) begin
                ar_log.push_back(araddr_o);
                r_addr = araddr_o;
            end
            if (rready_o) begin
                rvalid_i = 1'b1;
                rdata_i  = rd_fixed ? rd_fixed_val : rpat(r_addr);
                rresp_i  = (r_addr == err_araddr) ? 2'b10 : 2'b00;
            end else begin
                rvalid_i = 1'b0;
                rresp_i  = 2'b00;
            end
            if (awvalid_o) begin
                awready_i = (aw_cnt >= aw_wait);
                aw_cnt++;
            end else begin
                awready_i = 1'b0;
                aw_cnt = 0;
            end
            if (awvalid_o && awready_i) aw_log.push_back(awaddr_o);
            wready_i = wvalid_o;
            if (wvalid_o && wready_i) begin
                w_log.push_back(wdata_o);
                ws_log.push_back(wstrb_o);
            end
            bvalid_i = bready_o;
            if (bready_o) b_cnt++;
            ar_pend = arvalid_o && !arready_i; ar_prev = araddr_o;
            aw_pend = awvalid_o && !awready_i; aw_prev = awaddr_o;
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic rd, input logic ln, input logic [63:0] a,
                           input logic [LW-1:0] wl, input logic [SW-1:0] st);
        req_rd_i[p] = rd;
        req_line_i[p] = ln;
        req_addr_i[p*AW +: AW] = a;
        req_wdata_i[p*LW +: LW] = wl;
        req_wstrb_i[p*SW +: SW] = st;
    endtask

    // Called one cycle after acceptance with start=cycles already elapsed since acceptance.
    task automatic wait_resp(input int start, output int cyc);
        cyc = start;
        while (resp_vld_o == '0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("resp_arrived", (resp_vld_o != '0), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, ab, wb, bb, drops;
        logic [LW-1:0] wl;
        logic [NR-1:0] exp_g;
        logic [63:0]   rr_addr[2];

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_arvalid", arvalid_o, 0);
        check("rst_awvalid_wvalid", {awvalid_o, wvalid_o}, 0);
        check("rst_readies", {rready_o, bready_o}, 0);
        check("rst_resp_vld", resp_vld_o, 0);
        check("rst_resp_rdata_err", {resp_rdata_o, resp_err_o}, 0);
        check("rst_addrs", {araddr_o, awaddr_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("idle_no_grant", req_rdy_o, 0);

        // Port 0 single read at 0x1008, zero-wait slave
        rd_fixed = 1'b1;
        rd_fixed_val = 64'hDEADBEEF_CAFEF00D;
        set_req(0, 1'b1, 1'b0, 64'h1008, '0, '0);
        @(negedge clk);
        req_vld_i = 2'b01;
        #1 check("t1_grant", req_rdy_o, 2'b01);
        @(negedge clk);
        req_vld_i = 2'b00;
        check("t1_arvalid_T1", arvalid_o, 1);
        check("t1_araddr", araddr_o, 64'h1008);
        check("t1_busy_no_rdy", req_rdy_o, 0);
        @(negedge clk);
        check("t1_rready_T2", {rready_o, arvalid_o}, 2'b10);
        @(negedge clk);
        check("t1_resp_vld_T3", resp_vld_o, 2'b01);
        check("t1_rdata_low", resp_rdata_o[63:0], 64'hDEADBEEF_CAFEF00D);
        check("t1_rdata_upper_zero", resp_rdata_o[511:64], 0);
        check("t1_err", resp_err_o, 0);
        @(negedge clk);
        check("t1_resp_done", resp_vld_o, 0);
        rd_fixed = 1'b0;

        // Port 1 line read at 0x2030: beats at 0x2000..0x2038
        ab = ar_log.size();
        set_req(1, 1'b1, 1'b1, 64'h2030, '0, '0);
        @(negedge clk);
        req_vld_i = 2'b10;
        #1 check("t2_grant", req_rdy_o, 2'b10);
        @(negedge clk);
        req_vld_i = 2'b00;
        wait_resp(1, cyc);
        check("t2_latency", cyc, 17);
        check("t2_resp_vld", resp_vld_o, 2'b10);
        check("t2_ar_count", ar_log.size() - ab, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t2_araddr%0d", k), ar_log[ab + k], 64'h2000 + 64'(k * 8));
            check($sformatf("t2_rdata%0d", k), resp_rdata_o[k*64 +: 64], rpat(64'h2000 + 64'(k * 8)));
        end
        check("t2_err", resp_err_o, 0);
        @(negedge clk);

        // Port 0 line write at 0x3000, awready 3 cycles late, wready immediate
        for (int k = 0; k < 8; k++) wl[k*64 +: 64] = {32'h5000_0000 + 32'(k), 32'h0000_BEEF + 32'(k)};
        set_req(0, 1'b0, 1'b1, 64'h3000, wl, 8'h00);
        aw_wait = 3;
        ab = aw_log.size();
        wb = w_log.size();
        bb = b_cnt;
        @(negedge clk);
        req_vld_i = 2'b01;
        #1 check("t3_grant", req_rdy_o, 2'b01);
        @(negedge clk);
        req_vld_i = 2'b00;
        check("t3_aw_w_valid", {awvalid_o, wvalid_o, bready_o}, 3'b110);
        @(negedge clk);
        check("t3_w_dropped", {awvalid_o, wvalid_o, bready_o}, 3'b100);
        check("t3_awaddr", awaddr_o, 64'h3000);
        @(negedge clk);
        check("t3_aw_held", {awvalid_o, bready_o}, 2'b10);
        wait_resp(3, cyc);
        check("t3_latency", cyc, 41);
        check("t3_resp_vld", resp_vld_o, 2'b01);
        check("t3_b_count", b_cnt - bb, 8);
        check("t3_aw_count", aw_log.size() - ab, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t3_awaddr%0d", k), aw_log[ab + k], 64'h3000 + 64'(k * 8));
            check($sformatf("t3_wdata%0d", k), w_log[wb + k], wl[k*64 +: 64]);
            check($sformatf("t3_wstrb%0d", k), ws_log[wb + k], 8'hFF);
        end
        check("t3_err", resp_err_o, 0);
        check("t3_rdata_zero", resp_rdata_o, 0);
        check("t3_protocol", prot_err, 0);
        aw_wait = 0;
        @(negedge clk);

        // Line read at 0x4000 with SLVERR on beat 5 (0x4028)
        err_araddr = 64'h4028;
        ab = ar_log.size();
        set_req(0, 1'b1, 1'b1, 64'h4000, '0, '0);
        @(negedge clk);
        req_vld_i = 2'b01;
        @(negedge clk);
        req_vld_i = 2'b00;
        wait_resp(1, cyc);
        check("t4_latency", cyc, 17);
        check("t4_ar_count", ar_log.size() - ab, 8);
        check("t4_err_sticky", resp_err_o, 1);
        check("t4_beat7_data", resp_rdata_o[448 +: 64], rpat(64'h4038));
        err_araddr = '1;
        @(negedge clk);

        // After reset the pointer is 0: continuous requests on both ports alternate 0,1,0,1
        do_reset();
        rr_addr[0] = 64'h5000;
        rr_addr[1] = 64'h6008;
        set_req(0, 1'b1, 1'b0, rr_addr[0], '0, '0);
        set_req(1, 1'b1, 1'b0, rr_addr[1], '0, '0);
        req_vld_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            int n;
            n = 0;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            while (req_rdy_o == '0 && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
            check($sformatf("t5_grant%0d", i), req_rdy_o, exp_g);
            if (i == 2) resp_rdy_i = 2'b00;
            @(negedge clk);
            wait_resp(1, cyc);
            check($sformatf("t5_latency%0d", i), cyc, 3);
            check($sformatf("t5_resp_vld%0d", i), resp_vld_o, exp_g);
            check($sformatf("t5_rdata%0d", i), resp_rdata_o[63:0], rpat(rr_addr[i % 2]));
            check($sformatf("t5_err%0d", i), resp_err_o, 0);
            if (i == 2) begin
                repeat (5) begin
                    @(negedge clk);
                    check("t5_hold_vld", resp_vld_o, exp_g);
                    check("t5_hold_rdata", resp_rdata_o, {448'b0, rpat(rr_addr[0])});
                    #1 check("t5_hold_no_accept", req_rdy_o, 0);
                end
                resp_rdy_i = 2'b11;
            end
            @(negedge clk);
        end
        req_vld_i = 2'b00;

        // Without the watchdog, an unanswered AR stays asserted; reset abandons it
        ar_never = 1'b1;
        set_req(1, 1'b1, 1'b0, 64'h7000, '0, '0);
        @(negedge clk);
        req_vld_i = 2'b10;
        #1 check("t6_grant", req_rdy_o, 2'b10);
        @(negedge clk);
        req_vld_i = 2'b00;
        drops = 0;
        repeat (50) begin
            if (arvalid_o !== 1'b1 || araddr_o !== 64'h7000) drops++;
            @(negedge clk);
        end
        check("t6_arvalid_held", drops, 0);
        check("t6_no_resp", resp_vld_o, 0);
        rst_n = 1'b0;
        #1;
        check("t6_reset_arvalid", arvalid_o, 0);
        check("t6_reset_araddr", araddr_o, 0);
        check("t6_reset_resp", resp_vld_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ar_never = 1'b0;
        @(negedge clk);

        // Single-beat write with partial strobes; both ports valid, pointer back at 0
        ab = aw_log.size();
        wb = w_log.size();
        set_req(0, 1'b0, 1'b0, 64'h8004, {448'b0, 64'h0123_4567_89AB_CDEF}, 8'h0F);
        set_req(1, 1'b1, 1'b0, 64'h9000, '0, '0);
        req_vld_i = 2'b11;
        #1 check("t7_grant_after_reset", req_rdy_o, 2'b01);
        @(negedge clk);
        req_vld_i = 2'b00;
        wait_resp(1, cyc);
        check("t7_latency", cyc, 3);
        check("t7_resp_vld", resp_vld_o, 2'b01);
        check("t7_rdata_zero", resp_rdata_o, 0);
        check("t7_err", resp_err_o, 0);
        check("t7_aw_count", aw_log.size() - ab, 1);
        check("t7_awaddr", aw_log[ab], 64'h8000);
        check("t7_wdata", w_log[wb], 64'h0123_4567_89AB_CDEF);
        check("t7_wstrb", ws_log[wb], 8'h0F);
        check("t7_prot", {awprot_o, arprot_o}, 0);
        @(negedge clk);
        check("final_protocol", prot_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
